// File: rtl/snake_body_store_pkg.sv
// Shared definitions for the snake body store: grid geometry, coordinate
// types and the figure codes used when drawing cells.
package snake_body_store_pkg;

    localparam int COORD_W              = 7;
    localparam int GRID_W               = 124;
    localparam int GRID_H               = 81;
    localparam int SNAKE_LENGTH_BIT_DEF = 4;

    typedef logic [COORD_W-1:0] coord_val_t;

    typedef struct packed {
        coord_val_t x;
        coord_val_t y;
    } coord_t;

    typedef enum logic [2:0] {
        FIG_EMPTY,
        FIG_HEAD,
        FIG_BODY,
        FIG_TAIL,
        FIG_FRUIT
    } figure_e;

    function automatic coord_t make_coord(input coord_val_t x, input coord_val_t y);
        coord_t c;
        c.x = x;
        c.y = y;
        return c;
    endfunction

endpackage

// File: rtl/snake_body_store_if.sv
// Bundle between the game logic and the body store: move/grow requests and
// head position in, the segment stream and status flags out.
interface snake_body_store_if
    import snake_body_store_pkg::*;
#(
    parameter int SLB = SNAKE_LENGTH_BIT_DEF
) ();

    logic             move_tick;
    logic             grow;
    logic [COORD_W-1:0] snake_head_x;
    logic [COORD_W-1:0] snake_head_y;
    logic [SLB-1:0]   body_count;
    logic [COORD_W-1:0] snake_body_x;
    logic [COORD_W-1:0] snake_body_y;
    logic [SLB-1:0]   snake_length;
    logic             self_collision;
    logic             body_full;

    modport master (
        output move_tick, grow, snake_head_x, snake_head_y,
        input  body_count, snake_body_x, snake_body_y, snake_length,
               self_collision, body_full
    );

    modport slave (
        input  move_tick, grow, snake_head_x, snake_head_y,
        output body_count, snake_body_x, snake_body_y, snake_length,
               self_collision, body_full
    );

endinterface

// File: rtl/snake_body_store_scan_counter.sv
// Free-running segment index with sweep-end detection and a dirty flag that
// marks a sweep interrupted by a move.
module snake_body_store_scan_counter #(
    parameter int COUNT_BIT = 4
) (
    input  logic                 clock_25,
    input  logic                 reset,
    input  logic                 move_tick,
    output logic [COUNT_BIT-1:0] count,
    output logic [COUNT_BIT-1:0] next_count,
    output logic                 sweep_end,
    output logic                 dirty
);

    localparam logic [COUNT_BIT-1:0] LAST_INDEX = '1;

    assign next_count = count + COUNT_BIT'(1);
    assign sweep_end  = (count == LAST_INDEX);

    // A move on the last index still leaves the following sweep complete.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            count <= '0;
            dirty <= 1'b0;
        end else begin
            count <= next_count;
            if (move_tick) begin
                dirty <= !sweep_end;
            end else if (sweep_end) begin
                dirty <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/snake_body_store.sv
// Snake body segment store: shifts on move, grows on request, streams one
// segment per clock and reports head/body self-collision per full sweep.
module snake_body_store
    import snake_body_store_pkg::*;
#(
    parameter int         SNAKE_LENGTH_BIT = SNAKE_LENGTH_BIT_DEF,
    parameter int         INIT_LENGTH      = 3,
    parameter coord_val_t INIT_X           = 7'd20,
    parameter coord_val_t INIT_Y           = 7'd40
) (
    input logic               clock_25,
    input logic               reset,
    snake_body_store_if.slave bus
);

    localparam int SNAKE_LENGTH_MAX = 2 ** SNAKE_LENGTH_BIT;

    typedef logic [SNAKE_LENGTH_BIT-1:0] idx_t;

    localparam idx_t LENGTH_SAT  = idx_t'(SNAKE_LENGTH_MAX - 1);
    localparam idx_t LENGTH_INIT = idx_t'(INIT_LENGTH);

    function automatic coord_t reset_segment(input int i);
        return make_coord(coord_val_t'(int'(INIT_X) - 1 - i), INIT_Y);
    endfunction

    coord_t body      [SNAKE_LENGTH_MAX];
    coord_t body_next [SNAKE_LENGTH_MAX];
    coord_t head;
    coord_t seg_q;
    idx_t   body_count;
    idx_t   next_count;
    idx_t   snake_length;
    logic   grow_pending;
    logic   sweep_end;
    logic   dirty;
    logic   acc;
    logic   self_collision;
    logic   seg_hit;

    assign head = make_coord(bus.snake_head_x, bus.snake_head_y);

    snake_body_store_scan_counter #(
        .COUNT_BIT (SNAKE_LENGTH_BIT)
    ) u_scan_counter (
        .clock_25   (clock_25),
        .reset      (reset),
        .move_tick  (bus.move_tick),
        .count      (body_count),
        .next_count (next_count),
        .sweep_end  (sweep_end),
        .dirty      (dirty)
    );

    always_comb begin
        for (int i = 0; i < SNAKE_LENGTH_MAX; i++) begin
            body_next[i] = body[i];
        end
        if (bus.move_tick) begin
            body_next[0] = head;
            for (int i = 1; i < SNAKE_LENGTH_MAX; i++) begin
                body_next[i] = body[i-1];
            end
        end
    end

    // The stream reads the post-move array so a move shows up on the very next index.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SNAKE_LENGTH_MAX; i++) begin
                body[i] <= reset_segment(i);
            end
            seg_q <= reset_segment(0);
        end else begin
            for (int i = 0; i < SNAKE_LENGTH_MAX; i++) begin
                body[i] <= body_next[i];
            end
            seg_q <= body_next[next_count];
        end
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            snake_length <= LENGTH_INIT;
            grow_pending <= 1'b0;
        end else if (bus.move_tick) begin
            grow_pending <= 1'b0;
            if ((grow_pending || bus.grow) && (snake_length != LENGTH_SAT)) begin
                snake_length <= snake_length + idx_t'(1);
            end
        end else if (bus.grow) begin
            grow_pending <= 1'b1;
        end
    end

    assign seg_hit = (body_count < snake_length) && (seg_q == head);

    // Only a sweep that started after the latest move may update the flag.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            acc            <= 1'b0;
            self_collision <= 1'b0;
        end else if (bus.move_tick) begin
            acc <= 1'b0;
        end else if (sweep_end) begin
            acc <= 1'b0;
            if (!dirty) begin
                self_collision <= acc || seg_hit;
            end
        end else begin
            acc <= acc || seg_hit;
        end
    end

    assign bus.body_count     = body_count;
    assign bus.snake_body_x   = seg_q.x;
    assign bus.snake_body_y   = seg_q.y;
    assign bus.snake_length   = snake_length;
    assign bus.self_collision = self_collision;
    assign bus.body_full      = (snake_length == LENGTH_SAT);

endmodule

// File: tb/tb_snake_body_store.sv
// Directed bench for snake_body_store: reset, shifting, growth, saturation,
// sweep-based collision flag and asynchronous reset mid-stream.
module tb_snake_body_store;

    logic clock_25;
    logic reset;
    int   errors;
    int   checks;

    snake_body_store_if #(.SLB(4)) bus ();

    snake_body_store #(
        .SNAKE_LENGTH_BIT (4),
        .INIT_LENGTH      (3),
        .INIT_X           (7'd20),
        .INIT_Y           (7'd40)
    ) dut (
        .clock_25 (clock_25),
        .reset    (reset),
        .bus      (bus)
    );

    initial clock_25 = 1'b0;
    always #5 clock_25 = ~clock_25;

    // Returns at the next falling edge on which body_count equals k.
    task automatic wait_count(input int k);
        int n;
        n = 0;
        @(negedge clock_25);
        while (bus.body_count !== 4'(k) && n < 64) begin
            @(negedge clock_25);
            n++;
        end
        checks++;
        if (bus.body_count !== 4'(k)) begin
            errors++;
            $display("[TB] FAIL wait_count: body_count=%0d required %0d", bus.body_count, k);
        end
    endtask

    task automatic move_at(input int k, input logic [6:0] hx, input logic [6:0] hy,
                           input logic g, input logic [6:0] nx, input logic [6:0] ny);
        wait_count(k);
        bus.move_tick    = 1'b1;
        bus.grow         = g;
        bus.snake_head_x = hx;
        bus.snake_head_y = hy;
        @(negedge clock_25);
        bus.move_tick    = 1'b0;
        bus.grow         = 1'b0;
        bus.snake_head_x = nx;
        bus.snake_head_y = ny;
    endtask

    task automatic do_reset();
        reset            = 1'b0;
        bus.move_tick    = 1'b0;
        bus.grow         = 1'b0;
        bus.snake_head_x = 7'd20;
        bus.snake_head_y = 7'd40;
        repeat (2) @(negedge clock_25);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [6:0] ex [3];
        ex[0] = 7'd19;
        ex[1] = 7'd18;
        ex[2] = 7'd17;
        reset            = 1'b0;
        bus.move_tick    = 1'b0;
        bus.grow         = 1'b0;
        bus.snake_head_x = 7'd20;
        bus.snake_head_y = 7'd40;
        @(negedge clock_25);
        checks++;
        if (bus.snake_length !== 4'd3) begin
            errors++;
            $display("[TB] FAIL reset_length: got %0d required 3", bus.snake_length);
        end
        checks++;
        if (bus.body_count !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_count: got %0d required 0", bus.body_count);
        end
        checks++;
        if (bus.self_collision !== 1'b0 || bus.body_full !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: collision=%b full=%b required 0 0",
                     bus.self_collision, bus.body_full);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.body_count !== 4'(i) || bus.snake_body_x !== ex[i] || bus.snake_body_y !== 7'd40) begin
                errors++;
                $display("[TB] FAIL reset_stream%0d: got idx=%0d (%0d,%0d) required idx=%0d (%0d,40)",
                         i, bus.body_count, bus.snake_body_x, bus.snake_body_y, i, ex[i]);
            end
            @(negedge clock_25);
        end
    endtask

    task automatic test_move();
        logic [6:0] ex [3];
        ex[0] = 7'd20;
        ex[1] = 7'd19;
        ex[2] = 7'd18;
        move_at(5, 7'd20, 7'd40, 1'b0, 7'd21, 7'd40);
        wait_count(0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.snake_body_x !== ex[i] || bus.snake_body_y !== 7'd40) begin
                errors++;
                $display("[TB] FAIL move_seg%0d: got (%0d,%0d) required (%0d,40)",
                         i, bus.snake_body_x, bus.snake_body_y, ex[i]);
            end
            @(negedge clock_25);
        end
        checks++;
        if (bus.snake_length !== 4'd3) begin
            errors++;
            $display("[TB] FAIL move_length: got %0d required 3", bus.snake_length);
        end
    endtask

    task automatic test_grow_delayed();
        logic [6:0] ex [4];
        ex[0] = 7'd20;
        ex[1] = 7'd19;
        ex[2] = 7'd18;
        ex[3] = 7'd17;
        do_reset();
        bus.grow = 1'b1;
        @(negedge clock_25);
        bus.grow = 1'b0;
        repeat (100) @(negedge clock_25);
        checks++;
        if (bus.snake_length !== 4'd3) begin
            errors++;
            $display("[TB] FAIL grow_wait_length: got %0d required 3", bus.snake_length);
        end
        move_at(5, 7'd20, 7'd40, 1'b0, 7'd21, 7'd40);
        checks++;
        if (bus.snake_length !== 4'd4) begin
            errors++;
            $display("[TB] FAIL grow_length: got %0d required 4", bus.snake_length);
        end
        wait_count(0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.snake_body_x !== ex[i] || bus.snake_body_y !== 7'd40) begin
                errors++;
                $display("[TB] FAIL grow_seg%0d: got (%0d,%0d) required (%0d,40)",
                         i, bus.snake_body_x, bus.snake_body_y, ex[i]);
            end
            @(negedge clock_25);
        end
        move_at(5, 7'd21, 7'd40, 1'b0, 7'd22, 7'd40);
        checks++;
        if (bus.snake_length !== 4'd4) begin
            errors++;
            $display("[TB] FAIL grow_pending_cleared: got %0d required 4", bus.snake_length);
        end
    endtask

    task automatic test_grow_same_cycle();
        for (int len = 5; len <= 15; len++) begin
            move_at(5, 7'(30 + len), 7'd10, 1'b1, 7'(31 + len), 7'd10);
            checks++;
            if (bus.snake_length !== 4'(len) || bus.body_full !== logic'(len == 15)) begin
                errors++;
                $display("[TB] FAIL grow_same_len%0d: got len=%0d full=%b required len=%0d full=%b",
                         len, bus.snake_length, bus.body_full, len, (len == 15));
            end
        end
        move_at(5, 7'd50, 7'd10, 1'b1, 7'd51, 7'd10);
        checks++;
        if (bus.snake_length !== 4'd15 || bus.body_full !== 1'b1) begin
            errors++;
            $display("[TB] FAIL saturate_same: got len=%0d full=%b required len=15 full=1",
                     bus.snake_length, bus.body_full);
        end
        bus.grow = 1'b1;
        @(negedge clock_25);
        bus.grow = 1'b0;
        repeat (10) @(negedge clock_25);
        move_at(5, 7'd51, 7'd10, 1'b0, 7'd52, 7'd10);
        checks++;
        if (bus.snake_length !== 4'd15 || bus.body_full !== 1'b1) begin
            errors++;
            $display("[TB] FAIL saturate_pending: got len=%0d full=%b required len=15 full=1",
                     bus.snake_length, bus.body_full);
        end
    endtask

    task automatic test_collision();
        logic exp [4];
        exp[0] = 1'b0;
        exp[1] = 1'b1;
        exp[2] = 1'b1;
        exp[3] = 1'b0;
        do_reset();
        // After this move body[2]=(18,40) and the head sits on it.
        move_at(1, 7'd20, 7'd40, 1'b0, 7'd18, 7'd40);
        for (int s = 0; s < 2; s++) begin
            wait_count(0);
            checks++;
            if (bus.self_collision !== exp[s]) begin
                errors++;
                $display("[TB] FAIL collide_sweep%0d: got %b required %b", s, bus.self_collision, exp[s]);
            end
        end
        move_at(1, 7'd18, 7'd40, 1'b0, 7'd60, 7'd10);
        for (int s = 2; s < 4; s++) begin
            wait_count(0);
            checks++;
            if (bus.self_collision !== exp[s]) begin
                errors++;
                $display("[TB] FAIL collide_sweep%0d: got %b required %b", s, bus.self_collision, exp[s]);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        move_at(3, 7'd60, 7'd10, 1'b1, 7'd61, 7'd10);
        wait_count(7);
        checks++;
        if (bus.snake_length !== 4'd4) begin
            errors++;
            $display("[TB] FAIL pre_reset_length: got %0d required 4", bus.snake_length);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.body_count !== 4'd0 || bus.snake_body_x !== 7'd19 || bus.snake_body_y !== 7'd40) begin
            errors++;
            $display("[TB] FAIL async_reset_stream: got idx=%0d (%0d,%0d) required idx=0 (19,40)",
                     bus.body_count, bus.snake_body_x, bus.snake_body_y);
        end
        checks++;
        if (bus.snake_length !== 4'd3 || bus.self_collision !== 1'b0 || bus.body_full !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_status: got len=%0d coll=%b full=%b required 3 0 0",
                     bus.snake_length, bus.self_collision, bus.body_full);
        end
        @(negedge clock_25);
        reset = 1'b1;
        @(negedge clock_25);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_move();
        test_grow_delayed();
        test_grow_same_cycle();
        test_collision();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
